// File: rtl/mem_arbiter_if.sv
// Requester-side bus for the memory arbiter: CPU datapath (read/write) and
// program loader (write only). The requesters drive the master side and the
// arbiter implements the slave side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_addr, ld_wdata,
    input  cpu_rdata, cpu_ack, ld_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_addr, ld_wdata,
    output cpu_rdata, cpu_ack, ld_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port SLC-3 memory between the CPU datapath and the
// program loader, inserting fixed wait states and decoding one memory-mapped
// I/O word (reads return switches, writes latch the hex display value).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | sample requests, arbitrate, launch memory or I/O access
//  S_ACCESS | memory control held; cnt counts remaining wait cycles
//  S_DONE   | access finished; winner's ack registered for one cycle
module mem_arbiter #(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 16,
  parameter int              MEM_LAT    = 2,
  parameter int              STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] IO_ADDR  = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_arbiter_if.slave      bus,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [9:0]        SW,
  output logic [15:0]       hex_data,
  output logic              busy
);

  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [3:0]      LAT_M1     = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              winner_q, winner_d;   // 1 = loader owns the transaction
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0]       hex_q, hex_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ld_ack_q, ld_ack_d;

  logic              starved;
  logic              cpu_win;
  logic              ld_win;
  logic              io_hit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sw_ext;

  // Arbitration: loader first unless the CPU has waited STARVE_MAX grants.
  always_comb begin
    starved  = (starve_q == STARVE_LIM);
    cpu_win  = bus.cpu_req && (!bus.ld_req || starved);
    ld_win   = bus.ld_req && !cpu_win;
    sel_addr = ld_win ? bus.ld_addr : bus.cpu_addr;
    io_hit   = (sel_addr == IO_ADDR);
    sw_ext   = {{(DATA_W-10){1'b0}}, SW};
  end

  // State and datapath registers; synchronous reset abandons any transaction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      winner_q    <= 1'b0;
      starve_q    <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      hex_q       <= '0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      starve_q    <= starve_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      hex_q       <= hex_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
    end
  end

  // Next-state: I/O hits skip the wait states and go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_win || ld_win) state_d = io_hit ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: launch, wait-state count, capture, ack.
  always_comb begin
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    hex_d       = hex_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    starve_d    = bus.cpu_req ? starve_q : '0;
    case (state_q)
      S_IDLE: begin
        if (ld_win && bus.cpu_req) starve_d = starve_q + 1'b1;
        if (cpu_win) starve_d = '0;
        if (cpu_win || ld_win) begin
          winner_d = ld_win;
          if (io_hit) begin
            // Loader writes to the I/O word are acknowledged but dropped.
            if (cpu_win && !bus.cpu_we) cpu_rdata_d = sw_ext;
            if (cpu_win && bus.cpu_we)  hex_d = bus.cpu_wdata[15:0];
          end else begin
            mem_ce_d    = 1'b1;
            mem_we_d    = ld_win ? 1'b1 : bus.cpu_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = ld_win ? bus.ld_wdata : bus.cpu_wdata;
            cnt_d       = LAT_M1;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!winner_q && !mem_we_q) cpu_rdata_d = mem_rdata;
          mem_ce_d = 1'b0;
          mem_we_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (winner_q) ld_ack_d  = 1'b1;
        else          cpu_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_ce        = mem_ce_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign hex_data      = hex_q;
  assign busy          = (state_q != S_IDLE);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized back-to-back
// traffic, checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int          MEM_LAT    = 2;
  localparam int          STARVE_MAX = 4;
  localparam logic [15:0] IO_ADDR    = 16'hFFFF;
  localparam int          BUDGET     = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [9:0]  sw;
  logic [15:0] hex_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT),
    .STARVE_MAX(STARVE_MAX), .IO_ADDR(IO_ADDR)
  ) dut (
    .Clk(clk), .Reset(rst), .bus(bus),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .SW(sw), .hex_data(hex_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment memory: driven only by the DUT's memory bus.
  logic [15:0] env_mem [0:65535];
  always @(posedge clk) if (mem_ce && mem_we) env_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = env_mem[mem_addr];

  // Reference model: what memory/display/readback should hold.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_hex;
  logic [15:0] ref_rdata;

  // Cycles from request raise until ack is seen (sampling edge included).
  function automatic int exp_lat(input logic [15:0] a);
    return (a == IO_ADDR) ? 2 : MEM_LAT + 2;
  endfunction

  function automatic int exp_ce(input logic [15:0] a);
    return (a == IO_ADDR) ? 0 : MEM_LAT;
  endfunction

  task automatic cpu_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rdata,
                         output int ce_cyc, output int other_acks);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    lat = -1; rdata = '0; ce_cyc = 0; other_acks = 0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (mem_ce) ce_cyc++;
      if (bus.ld_ack) other_acks++;
      if (bus.cpu_ack) begin lat = c; rdata = bus.cpu_rdata; break; end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic ld_txn(input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output int ce_cyc, output int other_acks);
    bus.ld_req = 1'b1; bus.ld_addr = addr; bus.ld_wdata = wdata;
    lat = -1; ce_cyc = 0; other_acks = 0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (mem_ce) ce_cyc++;
      if (bus.cpu_ack) other_acks++;
      if (bus.ld_ack) begin lat = c; break; end
    end
    bus.ld_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ce, mem_we, busy, bus.cpu_ack, bus.ld_ack} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_ce, mem_we, busy, bus.cpu_ack, bus.ld_ack});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({bus.cpu_rdata, hex_data} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {bus.cpu_rdata, hex_data});
    end
    rst = 1'b0;
    ref_hex = '0; ref_rdata = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_mem_read();
    int lat, ce, oth; logic [15:0] rd;
    ld_txn(16'h0031, 16'h1234, lat, ce, oth);
    ref_mem[16'h0031] = 16'h1234;
    checks++;
    if (lat !== MEM_LAT + 2 || ce !== MEM_LAT || oth !== 0) begin
      errors++; $display("FAIL ld_write_timing: lat=%0d ce=%0d cpu_acks=%0d want %0d %0d 0", lat, ce, oth, MEM_LAT + 2, MEM_LAT);
    end
    cpu_txn(1'b0, 16'h0031, 16'h0, lat, rd, ce, oth);
    checks++;
    if (lat !== MEM_LAT + 2) begin
      errors++; $display("FAIL mem_read_lat: got %0d want %0d", lat, MEM_LAT + 2);
    end
    checks++;
    if (ce !== MEM_LAT || oth !== 0) begin
      errors++; $display("FAIL mem_read_ce: ce=%0d ld_acks=%0d want %0d 0", ce, oth, MEM_LAT);
    end
    checks++;
    if (rd !== ref_mem[16'h0031]) begin
      errors++; $display("FAIL mem_read_data: got %h want %h", rd, ref_mem[16'h0031]);
    end
    ref_rdata = rd;
  endtask

  task automatic test_io_read();
    int lat, ce, oth; logic [15:0] rd;
    sw = 10'h014;
    cpu_txn(1'b0, IO_ADDR, 16'h0, lat, rd, ce, oth);
    checks++;
    if (lat !== 2 || ce !== 0) begin
      errors++; $display("FAIL io_read_timing: lat=%0d ce=%0d want 2 0", lat, ce);
    end
    checks++;
    if (rd !== 16'h0014) begin
      errors++; $display("FAIL io_read_data: got %h want 0014", rd);
    end
    ref_rdata = 16'h0014;
  endtask

  task automatic test_io_write();
    int lat, ce, oth; logic [15:0] rd;
    cpu_txn(1'b1, IO_ADDR, 16'hBEEF, lat, rd, ce, oth);
    ref_hex = 16'hBEEF;
    checks++;
    if (lat !== 2 || ce !== 0 || hex_data !== ref_hex) begin
      errors++; $display("FAIL io_write: lat=%0d ce=%0d hex=%h want 2 0 %h", lat, ce, hex_data, ref_hex);
    end
    checks++;
    if (rd !== ref_rdata) begin
      errors++; $display("FAIL io_write_rdata_hold: got %h want %h", rd, ref_rdata);
    end
    ld_txn(IO_ADDR, 16'h1111, lat, ce, oth);
    checks++;
    if (lat !== 2 || ce !== 0 || hex_data !== ref_hex) begin
      errors++; $display("FAIL ld_io_write: lat=%0d ce=%0d hex=%h want 2 0 %h", lat, ce, hex_data, ref_hex);
    end
  endtask

  task automatic test_simultaneous();
    int ld_c, cpu_c; logic [15:0] rd;
    ld_c = -1; cpu_c = -1; rd = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040; bus.cpu_wdata = '0;
    bus.ld_req = 1'b1; bus.ld_addr = 16'h0040; bus.ld_wdata = 16'h5555;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (bus.ld_ack) begin ld_c = c; bus.ld_req = 1'b0; end
      if (bus.cpu_ack) begin cpu_c = c; rd = bus.cpu_rdata; bus.cpu_req = 1'b0; end
      if (ld_c > 0 && cpu_c > 0) break;
    end
    bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    ref_mem[16'h0040] = 16'h5555;
    checks++;
    if (ld_c !== MEM_LAT + 2 || cpu_c !== 2 * (MEM_LAT + 2)) begin
      errors++; $display("FAIL simul_order: ld_ack@%0d cpu_ack@%0d want %0d %0d", ld_c, cpu_c, MEM_LAT + 2, 2 * (MEM_LAT + 2));
    end
    checks++;
    if (rd !== ref_mem[16'h0040]) begin
      errors++; $display("FAIL simul_data: got %h want %h", rd, ref_mem[16'h0040]);
    end
    ref_rdata = rd;
  endtask

  task automatic test_starvation();
    int lat, ce, oth, ld_before, cpu_c, resume_c;
    logic [15:0] rd;
    ld_txn(16'h0050, 16'h7777, lat, ce, oth);
    ref_mem[16'h0050] = 16'h7777;
    ld_before = 0; cpu_c = -1; resume_c = -1; rd = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0050;
    bus.ld_req = 1'b1; bus.ld_addr = 16'h0060; bus.ld_wdata = 16'h0600;
    for (int c = 1; c <= 4 * BUDGET; c++) begin
      @(posedge clk); #1;
      if (bus.ld_ack) begin
        if (cpu_c < 0) ld_before++;
        else begin resume_c = c; bus.ld_req = 1'b0; break; end
      end
      if (bus.cpu_ack) begin cpu_c = c; rd = bus.cpu_rdata; bus.cpu_req = 1'b0; end
    end
    bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    ref_mem[16'h0060] = 16'h0600;
    checks++;
    if (ld_before !== STARVE_MAX || cpu_c !== (STARVE_MAX + 1) * (MEM_LAT + 2)) begin
      errors++; $display("FAIL starve_count: ld_acks=%0d cpu_ack@%0d want %0d %0d", ld_before, cpu_c, STARVE_MAX, (STARVE_MAX + 1) * (MEM_LAT + 2));
    end
    checks++;
    if (rd !== ref_mem[16'h0050]) begin
      errors++; $display("FAIL starve_data: got %h want %h", rd, ref_mem[16'h0050]);
    end
    checks++;
    if (resume_c !== cpu_c + MEM_LAT + 2) begin
      errors++; $display("FAIL starve_resume: ld_ack@%0d want %0d", resume_c, cpu_c + MEM_LAT + 2);
    end
    ref_rdata = rd;
  endtask

  task automatic test_reset_mid();
    int lat, ce, oth, stray; logic [15:0] rd;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0070; bus.cpu_wdata = 16'h9999;
    @(posedge clk); #1;
    checks++;
    if (mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0070) begin
      errors++; $display("FAIL rstmid_launch: ce=%b we=%b addr=%h want 1 1 0070", mem_ce, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_ce !== 1'b0 || busy !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: ce=%b busy=%b ack=%b want 0 0 0", mem_ce, busy, bus.cpu_ack);
    end
    rst = 1'b0;
    ref_hex = '0; ref_rdata = '0;
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.cpu_ack || bus.ld_ack || mem_ce) stray++;
    end
    checks++;
    if (stray !== 0 || hex_data !== ref_hex) begin
      errors++; $display("FAIL rstmid_quiet: stray=%0d hex=%h want 0 %h", stray, hex_data, ref_hex);
    end
    cpu_txn(1'b1, 16'h0070, 16'h9999, lat, rd, ce, oth);
    ref_mem[16'h0070] = 16'h9999;
    checks++;
    if (lat !== MEM_LAT + 2 || ce !== MEM_LAT || rd !== ref_rdata) begin
      errors++; $display("FAIL rstmid_reissue: lat=%0d ce=%0d rdata=%h want %0d %0d %h", lat, ce, rd, MEM_LAT + 2, MEM_LAT, ref_rdata);
    end
    cpu_txn(1'b0, 16'h0070, 16'h0, lat, rd, ce, oth);
    checks++;
    if (rd !== ref_mem[16'h0070]) begin
      errors++; $display("FAIL rstmid_readback: got %h want %h", rd, ref_mem[16'h0070]);
    end
    ref_rdata = rd;
  endtask

  task automatic test_back_to_back();
    int lat, ce, oth, kind, idx;
    logic [15:0] addr, data, rd, exp;
    for (int i = 0; i < 8; i++) begin
      data = 16'($urandom);
      ld_txn(16'h0100 + 16'(i), data, lat, ce, oth);
      ref_mem[16'h0100 + 16'(i)] = data;
    end
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      idx  = int'($urandom_range(0, 8));
      addr = (idx == 8) ? IO_ADDR : 16'h0100 + 16'(idx);
      data = 16'($urandom);
      sw   = 10'($urandom);
      if (kind == 0) begin
        cpu_txn(1'b0, addr, 16'h0, lat, rd, ce, oth);
        exp = (addr == IO_ADDR) ? {6'b0, sw} : ref_mem[addr];
        ref_rdata = exp;
      end else if (kind == 1) begin
        cpu_txn(1'b1, addr, data, lat, rd, ce, oth);
        if (addr == IO_ADDR) ref_hex = data;
        else ref_mem[addr] = data;
        exp = ref_rdata;
      end else begin
        ld_txn(addr, data, lat, ce, oth);
        if (addr != IO_ADDR) ref_mem[addr] = data;
        rd = bus.cpu_rdata;
        exp = ref_rdata;
      end
      checks++;
      if (lat !== exp_lat(addr) || ce !== exp_ce(addr) || oth !== 0) begin
        errors++; $display("FAIL rand_timing[%0d] kind=%0d addr=%h: lat=%0d ce=%0d other=%0d want %0d %0d 0",
                           n, kind, addr, lat, ce, oth, exp_lat(addr), exp_ce(addr));
      end
      checks++;
      if (rd !== exp || hex_data !== ref_hex) begin
        errors++; $display("FAIL rand_data[%0d] kind=%0d addr=%h: rdata=%h hex=%h want %h %h",
                           n, kind, addr, rd, hex_data, exp, ref_hex);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sw = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    ref_hex = '0; ref_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_mem_read();
    test_io_read();
    test_io_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
